// File: rtl/agg_window_ctrl.sv
// Window sequencer for the 12-bit bipolar aggregator: clears it, streams cfg_win_len samples, returns sum/activation.
// Optional build macro AGG_CTRL_CNT_EN adds the win_cnt completed-window counter and ovf_flag commit-overflow flag.
module agg_window_ctrl #(
  parameter int WIN_W = 10,
  parameter int AGG_W = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIN_W-1:0]        cfg_win_len,
  input  logic                    abort,
  input  logic                    s_valid,
  input  logic                    s_bit,
  output logic                    s_ready,
  output logic                    agg_rst,
  output logic                    agg_calc_1,
  output logic                    agg_calc_in,
  input  logic signed [AGG_W-1:0] agg_out2alu,
  input  logic                    agg_out_acted,
  output logic                    r_valid,
  output logic signed [AGG_W-1:0] r_sum,
  output logic                    r_act,
  input  logic                    r_ready,
  output logic                    busy
`ifdef AGG_CTRL_CNT_EN
  ,
  output logic [15:0]             win_cnt,
  output logic [0:0]              ovf_flag
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] ACCUM  = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] RESULT = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [WIN_W-1:0] remaining;
  logic             drain_cnt;
  logic             hs;
  logic             accept;

`ifdef AGG_CTRL_CNT_EN
  // A commit that would push the sum past either end of the AGG_W range.
  function automatic logic commit_ovf(input logic signed [AGG_W-1:0] sum, input logic sample);
    logic signed [AGG_W-1:0] max_v;
    logic signed [AGG_W-1:0] min_v;
    max_v = {1'b0, {(AGG_W-1){1'b1}}};
    min_v = {1'b1, {(AGG_W-1){1'b0}}};
    return sample ? (sum == max_v) : (sum == min_v);
  endfunction
`endif

  // Abort and reset both withdraw s_ready so no sample is acknowledged on the way out.
  assign s_ready     = (state == ACCUM) && !abort && !rst;
  assign hs          = s_valid && s_ready;
  assign agg_calc_1  = hs;
  assign agg_calc_in = hs && s_bit;
  assign agg_rst     = rst || (state == IDLE) || (state == CLEAR);
  assign r_valid     = (state == RESULT) && !rst;
  assign busy        = (state != IDLE) && !rst;
  assign accept      = (state == IDLE) && start && !abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CLEAR;
      CLEAR:   if (abort) state_nxt = IDLE;
               else if (remaining == '0) state_nxt = DRAIN;
               else state_nxt = ACCUM;
      ACCUM:   if (abort) state_nxt = IDLE;
               else if (hs && (remaining == WIN_W'(1))) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (drain_cnt) state_nxt = RESULT;
      RESULT:  if (r_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      drain_cnt <= 1'b0;
      r_sum     <= '0;
      r_act     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)
        remaining <= cfg_win_len;
      else if (hs && (remaining != '0))
        remaining <= remaining - WIN_W'(1);
      // Sum settles one cycle after the last commit, activation one cycle after that.
      drain_cnt <= (state == DRAIN) && !drain_cnt && !abort;
      if ((state == DRAIN) && drain_cnt && !abort) begin
        r_sum <= agg_out2alu;
        r_act <= agg_out_acted;
      end
    end
  end

`ifdef AGG_CTRL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt  <= 16'd0;
      ovf_flag <= 1'b0;
    end else begin
      if ((state == RESULT) && r_ready)
        win_cnt <= win_cnt + 16'd1;
      if (state == CLEAR)
        ovf_flag <= 1'b0;
      else if (hs && commit_ovf(agg_out2alu, s_bit))
        ovf_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_agg_window_ctrl.sv
// Directed self-checking bench for agg_window_ctrl with a behavioural aggregator model.
module tb_agg_window_ctrl;
  localparam int WIN_W = 10;
  localparam int AGG_W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [WIN_W-1:0]        cfg_win_len = '0;
  logic                    abort = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_bit = 1'b0;
  logic                    s_ready;
  logic                    agg_rst;
  logic                    agg_calc_1;
  logic                    agg_calc_in;
  logic signed [AGG_W-1:0] agg_out2alu;
  logic                    agg_out_acted;
  logic                    r_valid;
  logic signed [AGG_W-1:0] r_sum;
  logic                    r_act;
  logic                    r_ready = 1'b0;
  logic                    busy;
`ifdef AGG_CTRL_CNT_EN
  logic [15:0]             win_cnt;
  logic [0:0]              ovf_flag;
`endif

  int checks = 0;
  int errors = 0;

  agg_window_ctrl #(.WIN_W(WIN_W), .AGG_W(AGG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_win_len(cfg_win_len), .abort(abort),
    .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready),
    .agg_rst(agg_rst), .agg_calc_1(agg_calc_1), .agg_calc_in(agg_calc_in),
    .agg_out2alu(agg_out2alu), .agg_out_acted(agg_out_acted),
    .r_valid(r_valid), .r_sum(r_sum), .r_act(r_act), .r_ready(r_ready), .busy(busy)
`ifdef AGG_CTRL_CNT_EN
    , .win_cnt(win_cnt), .ovf_flag(ovf_flag)
`endif
  );

  // Aggregator: sum registered on commit, activation is the inverted sign of the registered sum.
  logic signed [AGG_W-1:0] sum_m;
  logic                    act_m;
  always @(posedge clk) begin
    if (agg_rst) begin
      sum_m <= '0;
      act_m <= 1'b0;
    end else begin
      if (agg_calc_1) sum_m <= sum_m + (agg_calc_in ? 12'sd1 : -12'sd1);
      act_m <= ~sum_m[AGG_W-1];
    end
  end
  assign agg_out2alu   = sum_m;
  assign agg_out_acted = act_m;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one window until r_valid; lat counts edges after the accepting edge (-1 on timeout).
  task automatic run_window(input int len, input logic [15:0] bits, input bit toggle,
                            output int commits, output int lat, output int ready_cycles,
                            output int bad_calc);
    commits = 0; lat = -1; ready_cycles = 0; bad_calc = 0;
    cfg_win_len = WIN_W'(len);
    start = 1'b1;
    s_valid = 1'b0;
    tick();
    start = 1'b0;
    cfg_win_len = WIN_W'(len) ^ WIN_W'(5);
    for (int c = 0; c < 60; c++) begin
      s_valid = toggle ? c[0] : 1'b1;
      s_bit = (commits < 16) ? bits[commits] : 1'b0;
      #1;
      if (r_valid) begin
        lat = c;
        break;
      end
      if (s_ready) ready_cycles++;
      if (agg_calc_1 !== (s_valid && s_ready)) bad_calc++;
      if (!agg_calc_1 && agg_calc_in) bad_calc++;
      if (agg_calc_1 && (agg_calc_in !== s_bit)) bad_calc++;
      if (agg_calc_1) commits++;
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic consume;
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({agg_rst, r_valid, busy, agg_calc_1, s_ready} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_outputs: got %b expected 10000", {agg_rst, r_valid, busy, agg_calc_1, s_ready});
      end
    end
    checks++;
    if (r_sum !== 12'h000) begin
      errors++;
      $display("FAIL reset_r_sum: got %h expected 000", r_sum);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({agg_rst, busy, r_valid, s_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 1000", {agg_rst, busy, r_valid, s_ready});
    end
  endtask

  task automatic test_window8;
    int commits, lat, rdy, bad;
    run_window(8, 16'b0000_0000_1101_1111, 1'b0, commits, lat, rdy, bad);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL w8_latency: got %0d expected 11", lat); end
    checks++;
    if (commits !== 8) begin errors++; $display("FAIL w8_commits: got %0d expected 8", commits); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL w8_calc_outputs: got %0d bad cycles expected 0", bad); end
    checks++;
    if (r_sum !== 12'h006) begin errors++; $display("FAIL w8_r_sum: got %h expected 006", r_sum); end
    checks++;
    if (r_act !== 1'b1) begin errors++; $display("FAIL w8_r_act: got %b expected 1", r_act); end
`ifdef AGG_CTRL_CNT_EN
    checks++;
    if (ovf_flag !== 1'b0) begin errors++; $display("FAIL w8_ovf_flag: got %b expected 0", ovf_flag); end
`endif
    consume();
    checks++;
    if ({busy, r_valid} !== 2'b00) begin errors++; $display("FAIL w8_consume: got %b expected 00", {busy, r_valid}); end
  endtask

  task automatic test_stall;
    int commits, lat, rdy, bad;
    run_window(4, 16'h0000, 1'b1, commits, lat, rdy, bad);
    checks++;
    if (commits !== 4) begin errors++; $display("FAIL stall_commits: got %0d expected 4", commits); end
    checks++;
    if (rdy !== 7) begin errors++; $display("FAIL stall_accum_cycles: got %0d expected 7", rdy); end
    checks++;
    if (lat !== 10) begin errors++; $display("FAIL stall_latency: got %0d expected 10", lat); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_calc_outputs: got %0d bad cycles expected 0", bad); end
    checks++;
    if ({r_sum, r_act} !== {12'hFFC, 1'b0}) begin
      errors++; $display("FAIL stall_result: got %h/%b expected FFC/0", r_sum, r_act);
    end
    consume();
  endtask

  task automatic test_zero_len;
    int commits, lat, rdy, bad;
    run_window(0, 16'hFFFF, 1'b0, commits, lat, rdy, bad);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL zero_latency: got %0d expected 3", lat); end
    checks++;
    if (rdy !== 0) begin errors++; $display("FAIL zero_s_ready: got %0d ready cycles expected 0", rdy); end
    checks++;
    if (r_sum !== 12'h000) begin errors++; $display("FAIL zero_r_sum: got %h expected 000", r_sum); end
    consume();
  endtask

  task automatic test_abort;
    int commits, lat, rdy, bad;
    cfg_win_len = WIN_W'(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_bit = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    s_valid = 1'b0;
    checks++;
    if ({busy, agg_rst, r_valid} !== 3'b010) begin
      errors++; $display("FAIL abort_to_idle: got %b expected 010", {busy, agg_rst, r_valid});
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({busy, r_valid} !== 2'b00) begin errors++; $display("FAIL abort_no_result: got %b expected 00", {busy, r_valid}); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_start: got busy %b expected 0", busy); end
    run_window(2, 16'h0003, 1'b0, commits, lat, rdy, bad);
    checks++;
    if (r_sum !== 12'h002) begin errors++; $display("FAIL abort_fresh_sum: got %h expected 002", r_sum); end
    consume();
  endtask

  task automatic test_result_hold;
    int commits, lat, rdy, bad;
    logic [15:0] cnt_before;
    run_window(3, 16'b001, 1'b0, commits, lat, rdy, bad);
    cnt_before = 16'd0;
`ifdef AGG_CTRL_CNT_EN
    cnt_before = win_cnt;
`endif
    for (int k = 0; k < 5; k++) begin
      start = k[0];
      abort = ~k[0];
      tick();
      checks++;
      if ({r_valid, r_sum, r_act} !== {1'b1, 12'hFFF, 1'b0}) begin
        errors++; $display("FAIL hold_result: got %b/%h/%b expected 1/FFF/0", r_valid, r_sum, r_act);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    consume();
    checks++;
    if ({busy, r_valid} !== 2'b00) begin errors++; $display("FAIL hold_release: got %b expected 00", {busy, r_valid}); end
`ifdef AGG_CTRL_CNT_EN
    checks++;
    if (win_cnt !== cnt_before + 16'd1) begin
      errors++; $display("FAIL win_cnt_inc: got %0d expected %0d", win_cnt, cnt_before + 16'd1);
    end
`else
    if (cnt_before != 16'd0) $display("unexpected counter snapshot");
`endif
  endtask

  task automatic test_rst_midwindow;
    cfg_win_len = WIN_W'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_bit = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({s_ready, agg_calc_1, agg_rst} !== 3'b001) begin
      errors++; $display("FAIL rst_mid_handshake: got %b expected 001", {s_ready, agg_calc_1, agg_rst});
    end
    tick();
    rst = 1'b0;
    s_valid = 1'b0;
    tick();
    checks++;
    if ({busy, r_valid, r_sum} !== {2'b00, 12'h000}) begin
      errors++; $display("FAIL rst_mid_state: got %b/%b/%h expected 0/0/000", busy, r_valid, r_sum);
    end
  endtask

  initial begin
    test_reset();
    test_window8();
    test_stall();
    test_zero_len();
    test_abort();
    test_result_hold();
    test_rst_midwindow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
